sdram_burst_master: RTL and testbench

- Application-side initiator for the SDRAM core's burst interface: decides when to issue write bursts (write-side FIFO → SDRAM) and read bursts (SDRAM → display-side FIFO).
- Drives the core's wr/rd burst request, length and address, and consumes the core's data-request, data-valid and finish strobes.
- Keeps independent wrapping frame address pointers for the write and read channels.
- Sits between the capture/display FIFOs and the SDRAM core.

---
 rtl/sdram_app_pkg.sv | 15 +
 rtl/burst_addr_gen.sv | 74 +++++++
 rtl/sdram_burst_master.sv | 134 +++++++++++++
 tb/tb_sdram_burst_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_app_pkg.sv
// Shared state encodings and width constants for the SDRAM application-side burst master.
package sdram_app_pkg;

  localparam int APP_ADDR_WIDTH  = 24;
  localparam int APP_BURST_WIDTH = 9;
  localparam int GAP_CYCLES      = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Per-channel frame pointer: base register, wrapping offset, deferred restart and frame_done pulse.
module burst_addr_gen #(
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 128,
  parameter int FRAME_LEN  = 786432
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  start,
  input  logic                  active,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  frame_done
);

  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] FRAME = ADDR_WIDTH'(FRAME_LEN);

  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH-1:0] offset_reg, offset_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] step_sum;
  logic                  pending_reg, pending_next;
  logic                  done_reg, done_next;

  always_comb begin
    base_next    = base_reg;
    offset_next  = offset_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;
    step_sum     = offset_reg + STEP;
    if (advance) begin
      pending_next = 1'b0;
      // A restart requested during this burst (or right now) replaces the increment.
      if (start || pending_reg) begin
        base_next   = base;
        offset_next = '0;
      end else if (step_sum == FRAME) begin
        offset_next = '0;
        done_next   = 1'b1;
      end else begin
        offset_next = step_sum;
      end
    end else if (start) begin
      if (active) begin
        pending_next = 1'b1;
      end else begin
        base_next   = base;
        offset_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg    <= base;
      offset_reg  <= '0;
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      done_reg    <= 1'b0;
    end else begin
      base_reg    <= base_next;
      offset_reg  <= offset_next;
      pending_reg <= pending_next;
      addr_reg    <= base_next + offset_next;
      done_reg    <= done_next;
    end
  end

  assign addr       = addr_reg;
  assign frame_done = done_reg;

endmodule

// File: rtl/sdram_burst_master.sv
// Arbitrates read/write bursts between the capture/display FIFOs and the SDRAM core burst port.
module sdram_burst_master #(
  parameter int APP_ADDR_WIDTH  = sdram_app_pkg::APP_ADDR_WIDTH,
  parameter int APP_BURST_WIDTH = sdram_app_pkg::APP_BURST_WIDTH,
  parameter int BURST_LEN       = 128,
  parameter int FRAME_LEN       = 786432,
  parameter int FIFO_LVL_WIDTH  = 10,
  parameter int RD_FIFO_DEPTH   = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [APP_ADDR_WIDTH-1:0]  wr_base_addr,
  input  logic [APP_ADDR_WIDTH-1:0]  rd_base_addr,
  input  logic                       wr_frame_start,
  input  logic                       rd_frame_start,
  input  logic [FIFO_LVL_WIDTH-1:0]  wr_fifo_level,
  input  logic [FIFO_LVL_WIDTH-1:0]  rd_fifo_level,
  output logic                       wr_fifo_rdreq,
  output logic                       rd_fifo_wrreq,
  output logic                       wr_burst_req,
  output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
  output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
  input  logic                       wr_burst_data_req,
  input  logic                       wr_burst_finish,
  output logic                       rd_burst_req,
  output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
  output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
  input  logic                       rd_burst_data_valid,
  input  logic                       rd_burst_finish,
  output logic                       wr_frame_done,
  output logic                       rd_frame_done,
  output logic                       busy
);

  import sdram_app_pkg::*;

  localparam logic [FIFO_LVL_WIDTH-1:0]  RD_ROOM  = FIFO_LVL_WIDTH'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [FIFO_LVL_WIDTH-1:0]  WR_AVAIL = FIFO_LVL_WIDTH'(BURST_LEN);
  localparam logic [1:0]                 GAP_LAST = 2'(GAP_CYCLES - 1);
  localparam logic [APP_BURST_WIDTH-1:0] LEN      = APP_BURST_WIDTH'(BURST_LEN);

  state_t     state_reg, state_next;
  logic [1:0] gap_cnt_reg, gap_cnt_next;
  logic       in_wr, in_rd;

  assign in_wr = (state_reg == S_WR);
  assign in_rd = (state_reg == S_RD);

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (rd_en && (rd_fifo_level <= RD_ROOM)) begin
          state_next = S_RD;
        end else if (wr_en && (wr_fifo_level >= WR_AVAIL)) begin
          state_next = S_WR;
        end
      end
      S_WR: begin
        if (wr_burst_finish) begin
          state_next   = S_GAP;
          gap_cnt_next = 2'd0;
        end
      end
      S_RD: begin
        if (rd_burst_finish) begin
          state_next   = S_GAP;
          gap_cnt_next = 2'd0;
        end
      end
      S_GAP: begin
        // Keeps req low while the core walks back into its idle state.
        gap_cnt_next = gap_cnt_reg + 2'd1;
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      gap_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  burst_addr_gen #(
    .ADDR_WIDTH (APP_ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .FRAME_LEN  (FRAME_LEN)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .base       (wr_base_addr),
    .start      (wr_frame_start),
    .active     (in_wr),
    .advance    (in_wr && wr_burst_finish),
    .addr       (wr_burst_addr),
    .frame_done (wr_frame_done)
  );

  burst_addr_gen #(
    .ADDR_WIDTH (APP_ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .FRAME_LEN  (FRAME_LEN)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .base       (rd_base_addr),
    .start      (rd_frame_start),
    .active     (in_rd),
    .advance    (in_rd && rd_burst_finish),
    .addr       (rd_burst_addr),
    .frame_done (rd_frame_done)
  );

  // Requests drop combinationally with finish so the core never sees a second request.
  assign wr_burst_req  = in_wr && !wr_burst_finish;
  assign rd_burst_req  = in_rd && !rd_burst_finish;
  assign wr_fifo_rdreq = wr_burst_data_req && in_wr;
  assign rd_fifo_wrreq = rd_burst_data_valid && in_rd;
  assign wr_burst_len  = LEN;
  assign rd_burst_len  = LEN;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sdram_burst_master.sv
// Directed bench for sdram_burst_master with a small behavioural SDRAM-core burst model.
module tb_sdram_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [23:0] wr_base_addr, rd_base_addr;
  logic        wr_frame_start, rd_frame_start;
  logic [9:0]  wr_fifo_level, rd_fifo_level;
  logic        wr_fifo_rdreq, rd_fifo_wrreq;
  logic        wr_burst_req, rd_burst_req;
  logic [8:0]  wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic        wr_burst_data_req, wr_burst_finish;
  logic        rd_burst_data_valid, rd_burst_finish;
  logic        wr_frame_done, rd_frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_burst_master #(
    .BURST_LEN     (8),
    .FRAME_LEN     (32),
    .RD_FIFO_DEPTH (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wr_en               (wr_en),
    .rd_en               (rd_en),
    .wr_base_addr        (wr_base_addr),
    .rd_base_addr        (rd_base_addr),
    .wr_frame_start      (wr_frame_start),
    .rd_frame_start      (rd_frame_start),
    .wr_fifo_level       (wr_fifo_level),
    .rd_fifo_level       (rd_fifo_level),
    .wr_fifo_rdreq       (wr_fifo_rdreq),
    .rd_fifo_wrreq       (rd_fifo_wrreq),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_finish     (wr_burst_finish),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_finish     (rd_burst_finish),
    .wr_frame_done       (wr_frame_done),
    .rd_frame_done       (rd_frame_done),
    .busy                (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Core model: waits for req, checks address/len, strobes 8 data cycles, pulses finish,
  // then follows the two gap cycles back to idle.
  task automatic run_burst(input bit rd, input logic [23:0] exp_addr, input bit exp_done,
                           input bit restart, input string tag);
    int  n;
    int  pops;
    bit  seen_other;
    logic done_seen;
    n = 0;
    seen_other = 1'b0;
    while (!(rd ? rd_burst_req : wr_burst_req) && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (rd ? wr_burst_req : rd_burst_req) seen_other = 1'b1;
    end
    chk({tag, "_req_seen"}, 32'(n < 40), 32'd1);
    chk({tag, "_other_req"}, 32'(seen_other), 32'd0);
    chk({tag, "_addr"}, 32'(rd ? rd_burst_addr : wr_burst_addr), 32'(exp_addr));
    chk({tag, "_len"}, 32'(rd ? rd_burst_len : wr_burst_len), 32'd8);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd) rd_burst_data_valid = 1'b1; else wr_burst_data_req = 1'b1;
      if (restart && i == 2) begin
        if (rd) rd_frame_start = 1'b1; else wr_frame_start = 1'b1;
      end else begin
        rd_frame_start = 1'b0;
        wr_frame_start = 1'b0;
      end
      #1;
      if (rd ? rd_fifo_wrreq : wr_fifo_rdreq) pops++;
    end
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;
    rd_frame_start      = 1'b0;
    wr_frame_start      = 1'b0;
    if (rd) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
    #1;
    chk({tag, "_pops"}, 32'(pops), 32'd8);
    chk({tag, "_req_at_finish"}, 32'(rd ? rd_burst_req : wr_burst_req), 32'd0);
    chk({tag, "_addr_hold"}, 32'(rd ? rd_burst_addr : wr_burst_addr), 32'(exp_addr));
    @(negedge clk);
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    #1;
    done_seen = rd ? rd_frame_done : wr_frame_done;
    chk({tag, "_gap1_busy"}, 32'(busy), 32'd1);
    chk({tag, "_gap1_req"}, 32'(rd ? rd_burst_req : wr_burst_req), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_gap2_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_width"}, 32'(rd ? rd_frame_done : wr_frame_done), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(done_seen), 32'(exp_done));
    $display("%s: %s burst addr=0x%0h pops=%0d frame_done=%0d", tag, rd ? "RD" : "WR",
             exp_addr, pops, done_seen);
  endtask

  initial begin
    int n;
    int busy_cnt;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_base_addr = 24'h100; rd_base_addr = 24'h200;
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wr_fifo_level = 10'd0; rd_fifo_level = 10'd0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset during an active write burst.
    wr_en = 1'b1; wr_fifo_level = 10'd8;
    n = 0;
    while (!wr_burst_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_pre_req", 32'(wr_burst_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_wr_req", 32'(wr_burst_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_addr", 32'(wr_burst_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_burst_addr), 32'd0);
    chk("rst_outs", 32'({rd_burst_req, wr_fifo_rdreq, rd_fifo_wrreq, wr_frame_done, rd_frame_done}), 32'd0);
    $display("reset: busy=%0d wr_req=%0d wr_addr=0x%0h", busy, wr_burst_req, wr_burst_addr);
    rst = 1'b0;

    // Write-only frame: four bursts, wrap, and back to base.
    run_burst(1'b0, 24'h100, 1'b0, 1'b0, "wr0");
    run_burst(1'b0, 24'h108, 1'b0, 1'b0, "wr1");
    run_burst(1'b0, 24'h110, 1'b0, 1'b0, "wr2");
    run_burst(1'b0, 24'h118, 1'b1, 1'b0, "wr3");
    run_burst(1'b0, 24'h100, 1'b0, 1'b0, "wr4");

    // Read wins arbitration over a simultaneously ready write.
    rd_en = 1'b1; rd_fifo_level = 10'd0;
    run_burst(1'b1, 24'h200, 1'b0, 1'b0, "prio_rd");
    rd_fifo_level = 10'd9;
    run_burst(1'b0, 24'h108, 1'b0, 1'b0, "prio_wr");
    wr_en = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (busy || rd_burst_req) busy_cnt++;
    end
    chk("no_rd_lvl9", 32'(busy_cnt), 32'd0);
    $display("no_rd_lvl9: busy_cycles=%0d", busy_cnt);

    // Restart requested mid-burst takes effect only after that burst.
    rd_fifo_level = 10'd0;
    run_burst(1'b1, 24'h208, 1'b0, 1'b0, "rd1");
    rd_base_addr = 24'h400;
    run_burst(1'b1, 24'h210, 1'b0, 1'b1, "rd_restart");
    run_burst(1'b1, 24'h400, 1'b0, 1'b0, "rd_new_base");
    rd_en = 1'b0;

    // Stray finish strobes in idle are ignored.
    @(negedge clk);
    wr_burst_finish = 1'b1; rd_burst_finish = 1'b1;
    @(negedge clk);
    wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (busy || wr_frame_done || rd_frame_done) busy_cnt++;
    end
    chk("stray_idle", 32'(busy_cnt), 32'd0);
    $display("stray_finish: disturbed_cycles=%0d", busy_cnt);
    wr_en = 1'b1;
    run_burst(1'b0, 24'h110, 1'b0, 1'b0, "stray_wr");
    wr_en = 1'b0;

    // Restart while idle reloads the base immediately.
    wr_base_addr = 24'h300;
    @(negedge clk);
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    wr_en = 1'b1;
    run_burst(1'b0, 24'h300, 1'b0, 1'b0, "idle_restart");
    wr_en = 1'b0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
